alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered downstream stage for the N-bit ALU. Captures the result Q, the flags Ne/Z/V/C and the ALUControl opcode in a 2-entry skid buffer using valid/ready handshakes.
- Maintains the architectural NZCV status register, updated per opcode class.
- Counts illegal opcodes.
- Decouples the combinational ALU from the writeback/consumer logic.

Parameters:
- N, 4, datapath width (must match the ALU's N)
- ERRW, 8, width of the illegal-opcode counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept (registered)
- alu_q  in  N  ALU result Q
- alu_ne  in  1  ALU negative flag
- alu_z  in  1  ALU zero flag
- alu_v  in  1  ALU overflow flag
- alu_c  in  1  ALU carry flag
- alu_op  in  4  ALUControl used for this result
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry
- out_q  out  N  head result
- out_op  out  4  head opcode
- out_flags  out  4  head flags {N,Z,C,V}
- nzcv  out  4  status register {N,Z,C,V}
- err_cnt  out  ERRW  illegal-opcode count, saturating
- clr_sticky  in  1  clears sticky_v (ignored when feature compiled out)
- sticky_v  out  1  sticky overflow (tied 0 when feature compiled out)

Behaviour:
- Reset (rst=1 at clk edge): buffer emptied, out_valid=0, in_ready=1, out_q/out_op/out_flags=0, nzcv=0, err_cnt=0, sticky_v=0. Reset overrides any handshake in the same cycle; in-flight entries are discarded.
- Accept: in_valid & in_ready at an edge. Push: entry {alu_q, alu_op, {alu_ne, alu_z, alu_c, alu_v}}.
- Pop: out_valid & out_ready at an edge.
- Latency: accepted entry visible on out_* the next cycle when the buffer was empty. Throughput: 1 entry/cycle sustained while out_ready=1.
- Occupancy 0/1/2:
  - in_ready = (occupancy<2), registered from next-state occupancy.
  - out_valid = (occupancy>0).
  - Simultaneous push+pop at occupancy 1 or 2: occupancy unchanged, order preserved.
  - Push at 0 while popping is impossible: out_valid=0 at occupancy 0.
- Ordering: strict FIFO. Head entry is stable while out_valid & !out_ready.
- Opcode classes:
  - 0 add, 1 sub, 2 mul: update N,Z,C,V.
  - 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 sll, 9 srl: update N,Z only; C,V held.
  - 10..15 illegal: entry still buffered, nzcv unchanged, err_cnt+1, saturating at 2^ERRW-1.
- nzcv and err_cnt update at the accept edge, not at pop, so status reflects issue order.
- Flags are passed through unmodified into out_flags; masking applies only to nzcv.
- in_valid while in_ready=0: no capture, no status/counter update; the upstream holds its data.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN
- Defined:
  - sticky_v sets on any accept with opcode class add/sub/mul and alu_v=1.
  - Cleared by clr_sticky=1 at an edge.
  - If set and clear occur the same cycle, set wins.
- Undefined: sticky_v constant 0, clr_sticky unused, no flop inferred.

Decomposition:
- Package alu_pkg:
  - typedef enum logic[3:0] alu_op_e (OP_ADD=0..OP_SRL=9)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - function flag_mask(alu_op_e) returning 4-bit update mask
  - function op_is_legal
- Sub-module: skid_buf2 #(W). Generic 2-entry valid/ready buffer holding {q,op,flags}.
- The top level owns nzcv, err_cnt and sticky logic.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill 2 entries with out_ready=0, then rst=1 for 1 cycle.
  - Required: out_valid=0, in_ready=1, nzcv=0, err_cnt=0 next cycle.
- Add class:
  - Stimulus: op=0, q=4'h0, z=1, c=1, v=0, ne=0, out_ready=1.
  - Required: next cycle out_valid=1, out_q=0, out_flags=4'b0110, nzcv=4'b0110.
- Logic class holds C/V:
  - Stimulus: after nzcv=4'b0011, send op=5 (and), q=4'h8, ne=1, z=0, c=0, v=0.
  - Required: nzcv=4'b1011; out_flags=4'b1000.
- Backpressure:
  - Stimulus: out_ready=0, send 3 back-to-back results q=1,2,3.
  - Required: in_ready falls after 2 accepts; q=3 is held upstream.
  - Then: raise out_ready; outputs appear in order 1,2,3, one per cycle, no loss or duplication.
- Illegal opcode:
  - Stimulus: op=4'hC, v=1.
  - Required: entry delivered with out_op=C, nzcv unchanged, err_cnt=1.
  - Saturation: with ERRW=2, 5 illegal ops give err_cnt=3.
- Sticky overflow (ALU_STICKY_OVF_EN):
  - Stimulus: op=1 with v=1, then op=0 with v=0.
  - Required: sticky_v stays 1 while nzcv.V becomes 0.
  - Then: clr_sticky=1 coincident with an overflowing op gives sticky_v=1; clr_sticky alone gives 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result stage: opcode enum, flag positions,
// per-opcode status-update mask and the skid-buffer occupancy states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Bits set in the mask are the NZCV bits this opcode is allowed to overwrite.
  function automatic logic [3:0] flag_mask(alu_op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL:                  flag_mask = 4'b1111;
      OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL:                          flag_mask = 4'b1100;
      default:                                 flag_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic op_is_legal(logic [3:0] op);
    op_is_legal = (op <= 4'd9);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready bus between the combinational ALU, the result stage and its consumer.
interface alu_result_stage_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] alu_q;
  logic         alu_ne;
  logic         alu_z;
  logic         alu_v;
  logic         alu_c;
  logic [3:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_q;
  logic [3:0]   out_op;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, alu_q, alu_ne, alu_z, alu_v, alu_c, alu_op, out_ready,
    input  in_ready, out_valid, out_q, out_op, out_flags
  );

  modport slave (
    input  in_valid, alu_q, alu_ne, alu_z, alu_v, alu_c, alu_op, out_ready,
    output in_ready, out_valid, out_q, out_op, out_flags
  );
endinterface

// File: rtl/alu_result_stage_skid_buf2.sv
// Generic 2-entry valid/ready FIFO (skid buffer) with a registered in_ready.
module skid_buf2 import alu_pkg::*; #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         occ, occ_nxt;
  logic [W-1:0] head, head_nxt;
  logic [W-1:0] tail, tail_nxt;
  logic         push, pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = head;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
    end else begin
      occ      <= occ_nxt;
      in_ready <= (occ_nxt != OCC_FULL);
      head     <= head_nxt;
    end
  end

  // NOTE: tail is never observed while empty, so it has no reset; keeping it out
  // of the reset block avoids turning rst into a data-path enable.
  always_ff @(posedge clk) begin
    tail <= tail_nxt;
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    unique case (occ)
      OCC_EMPTY: begin
        if (push) begin
          occ_nxt  = OCC_ONE;
          head_nxt = in_data;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            occ_nxt  = OCC_FULL;
            tail_nxt = in_data;
          end
          2'b01: occ_nxt  = OCC_EMPTY;
          2'b11: head_nxt = in_data;
          default: ;
        endcase
      end
      OCC_FULL: begin
        if (pop) begin
          head_nxt = tail;
          if (push) tail_nxt = in_data;
          else      occ_nxt  = OCC_ONE;
        end
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: skid-buffered results plus NZCV status, illegal-op
// counter and optional sticky overflow (enabled by defining ALU_STICKY_OVF_EN).
module alu_result_stage import alu_pkg::*; #(
  parameter int N    = 4,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_result_stage_if.slave bus,
  output logic [3:0]      nzcv,
  output logic [ERRW-1:0] err_cnt,
  input  logic            clr_sticky,
  output logic            sticky_v
);

  localparam int W = N + 8;

  logic         accept;
  logic [3:0]   in_flags;
  logic [3:0]   mask;
  logic [W-1:0] out_data;

  assign accept   = bus.in_valid & bus.in_ready;
  assign in_flags = {bus.alu_ne, bus.alu_z, bus.alu_c, bus.alu_v};
  assign mask     = flag_mask(alu_op_e'(bus.alu_op));

  skid_buf2 #(.W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.alu_q, bus.alu_op, in_flags}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );

  assign {bus.out_q, bus.out_op, bus.out_flags} = out_data;

  // Status follows issue order, so it updates on accept rather than on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv    <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      nzcv <= (nzcv & ~mask) | (in_flags & mask);
      if (!op_is_legal(bus.alu_op) && (err_cnt != {ERRW{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // Set has priority over clear when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                                        sticky_v <= 1'b0;
    else if (accept && mask[FLAG_V] && bus.alu_v)   sticky_v <= 1'b1;
    else if (clr_sticky)                            sticky_v <= 1'b0;
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, scoreboarded bench for alu_result_stage (ERRW=2 to reach saturation).
module tb_alu_result_stage;
  localparam int N    = 4;
  localparam int ERRW = 2;

  typedef struct {
    logic [3:0] q;
    logic [3:0] op;
    logic [3:0] fl;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr_sticky;
  logic [3:0]      nzcv;
  logic [ERRW-1:0] err_cnt;
  logic            sticky_v;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];

  logic [3:0] m_nzcv;
  int         m_err;
  logic       m_sticky;
  logic [3:0] saved_nzcv;

  alu_result_stage_if #(.N(N)) bus ();

  alu_result_stage #(.N(N), .ERRW(ERRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .nzcv       (nzcv),
    .err_cnt    (err_cnt),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] q,
                       input logic ne, input logic z, input logic c, input logic ov);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.alu_q    = q;
    bus.alu_ne   = ne;
    bus.alu_z    = z;
    bus.alu_c    = c;
    bus.alu_v    = ov;
  endtask

  // One clock: decide handshakes from pre-edge values, update model, then check status.
  task automatic cycle();
    logic acc, pp;
    ent_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    pp  = bus.out_valid && bus.out_ready;
    if (rst) begin
      sb.delete();
      m_nzcv   = '0;
      m_err    = 0;
      m_sticky = 1'b0;
    end else begin
      if (pp) begin
        if (sb.size() == 0) begin
          check("pop_on_empty_scoreboard", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_q", bus.out_q, e.q);
          check("out_op", bus.out_op, e.op);
          check("out_flags", bus.out_flags, e.fl);
        end
      end
      if (acc) begin
        e.q  = bus.alu_q;
        e.op = bus.alu_op;
        e.fl = {bus.alu_ne, bus.alu_z, bus.alu_c, bus.alu_v};
        sb.push_back(e);
        if (bus.alu_op <= 4'd2)      m_nzcv = e.fl;
        else if (bus.alu_op <= 4'd9) m_nzcv = {e.fl[3:2], m_nzcv[1:0]};
        else if (m_err < 3)          m_err++;
      end
`ifdef ALU_STICKY_OVF_EN
      if (acc && bus.alu_op <= 4'd2 && bus.alu_v) m_sticky = 1'b1;
      else if (clr_sticky)                        m_sticky = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    check("in_ready", bus.in_ready, (sb.size() < 2) ? 32'd1 : 32'd0);
    check("out_valid", bus.out_valid, (sb.size() > 0) ? 32'd1 : 32'd0);
    check("nzcv", nzcv, m_nzcv);
    check("err_cnt", err_cnt, m_err);
    check("sticky_v", sticky_v, m_sticky);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr_sticky = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cycle();
    cycle();
    check("reset_out_q", bus.out_q, 32'd0);
    check("reset_out_op", bus.out_op, 32'd0);
    check("reset_out_flags", bus.out_flags, 32'd0);
    rst = 1'b0;

    // Add class: all four flags taken
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("add_nzcv", nzcv, 32'b0110);
    check("add_out_flags", bus.out_flags, 32'b0110);
    drive(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Logic class keeps C/V
    drive(1'b1, 4'd0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    check("pre_logic_nzcv", nzcv, 32'b0011);
    drive(1'b1, 4'd5, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check("and_nzcv", nzcv, 32'b1011);
    check("and_out_flags", bus.out_flags, 32'b1000);
    drive(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Backpressure: third result must wait upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 4'd1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 4'd1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("bp_in_ready_low", bus.in_ready, 32'd0);
    check("bp_head_stable", bus.out_q, 32'h1);
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();

    // Illegal opcodes: buffered, nzcv held, counter saturates at 3
    saved_nzcv = nzcv;
    drive(1'b1, 4'hC, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("illegal_out_op", bus.out_op, 32'hC);
    check("illegal_nzcv_held", nzcv, saved_nzcv);
    check("illegal_err1", err_cnt, 32'd1);
    for (int i = 0; i < 4; i++) cycle();
    check("illegal_err_sat", err_cnt, 32'd3);
    drive(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Sticky overflow (model expects 0 throughout when compiled out)
    drive(1'b1, 4'd1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 4'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("sticky_nzcv_v_clear", nzcv[0], 32'd0);
`ifdef ALU_STICKY_OVF_EN
    check("sticky_held", sticky_v, 32'd1);
`endif
    clr_sticky = 1'b1;
    drive(1'b1, 4'd2, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
`ifdef ALU_STICKY_OVF_EN
    check("sticky_set_wins", sticky_v, 32'd1);
`endif
    drive(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("sticky_cleared", sticky_v, 32'd0);
    clr_sticky = 1'b0;
    cycle();

    // Reset mid-stream with two entries buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 4'd1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 32'd0);
    check("midrst_in_ready", bus.in_ready, 32'd1);
    check("midrst_nzcv", nzcv, 32'd0);
    check("midrst_err_cnt", err_cnt, 32'd0);
    bus.out_ready = 1'b1;
    cycle();
    check("final_scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
